// File: rtl/tile_ram_if.sv
// Requester-side and RAM-side signals of the tile RAM arbiter.
// master = requesters plus the RAM itself; slave = the arbiter.
interface tile_ram_if #(
   parameter int unsigned AW = 13,
   parameter int unsigned DW = 6
);
   logic          vid_req;
   logic [AW-1:0] vid_addr;
   logic [DW-1:0] vid_rdata;
   logic          vid_valid;
   logic          clr_start;
   logic [DW-1:0] clr_tile;
   logic          clr_busy;
   logic          clr_done;
   logic          host_req;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_data;
   logic          host_ack;
   logic          host_err;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic          ram_we;
   logic [DW-1:0] ram_rdata;

   modport master (
      output vid_req, vid_addr, clr_start, clr_tile, host_req, host_addr, host_data, ram_rdata,
      input  vid_rdata, vid_valid, clr_busy, clr_done, host_ack, host_err,
             ram_addr, ram_wdata, ram_we
   );

   modport slave (
      input  vid_req, vid_addr, clr_start, clr_tile, host_req, host_addr, host_data, ram_rdata,
      output vid_rdata, vid_valid, clr_busy, clr_done, host_ack, host_err,
             ram_addr, ram_wdata, ram_we
   );
endinterface

// File: rtl/tile_ram_arbiter.sv
// Owner of the single-port tile-ID RAM: fixed priority video read > clear fill > host write,
// with a two-stage video read pipeline and a clear-screen sequencer.
module tile_ram_arbiter #(
   parameter int unsigned TILES = 4800,
   parameter int unsigned AW    = 13,
   parameter int unsigned DW    = 6
) (
   input  logic       clk,
   input  logic       reset,
   tile_ram_if.slave  bus
);
   localparam logic [AW-1:0] LastTile  = AW'(TILES - 1);
   localparam logic [AW:0]   TileLimit = (AW + 1)'(TILES);

   typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] clr_ptr_q, clr_ptr_d;
   logic [DW-1:0] clr_val_q, clr_val_d;
   logic          rd_pend_q;
   logic          vid_valid_q;
   logic [DW-1:0] vid_rdata_q;

   logic          clr_own;
   logic          host_in_range;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic          ram_we;
   logic          host_ack;
   logic          host_err;

   // Extra MSB keeps the range check correct even when TILES == 2**AW.
   assign host_in_range = ({1'b0, bus.host_addr} < TileLimit);

   // Port grant, one owner per cycle.
   always_comb begin
      ram_addr  = '0;
      ram_wdata = '0;
      ram_we    = 1'b0;
      host_ack  = 1'b0;
      host_err  = 1'b0;
      clr_own   = 1'b0;
      if (bus.vid_req) begin
         ram_addr = bus.vid_addr;
      end else if (state_q == StClear) begin
         ram_addr  = clr_ptr_q;
         ram_wdata = clr_val_q;
         ram_we    = 1'b1;
         clr_own   = 1'b1;
      end else if (state_q == StIdle && bus.host_req && !bus.clr_start) begin
         // Held off through DONE so a stalled write is acked strictly after clr_done.
         host_ack = 1'b1;
         if (host_in_range) begin
            ram_addr  = bus.host_addr;
            ram_wdata = bus.host_data;
            ram_we    = 1'b1;
         end else begin
            host_err = 1'b1;
         end
      end
      if (!reset) begin
         ram_we   = 1'b0;
         host_ack = 1'b0;
         host_err = 1'b0;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      clr_val_d = clr_val_q;
      unique case (state_q)
         StIdle: begin
            if (bus.clr_start) begin
               clr_val_d = bus.clr_tile;
               clr_ptr_d = '0;
               state_d   = StClear;
            end
         end
         StClear: begin
            if (clr_own) begin
               if (clr_ptr_q == LastTile) begin
                  state_d = StDone;
               end else begin
                  clr_ptr_d = clr_ptr_q + 1'b1;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         clr_ptr_q   <= '0;
         clr_val_q   <= '0;
         rd_pend_q   <= 1'b0;
         vid_valid_q <= 1'b0;
         vid_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         clr_ptr_q   <= clr_ptr_d;
         clr_val_q   <= clr_val_d;
         rd_pend_q   <= bus.vid_req;
         vid_valid_q <= rd_pend_q;
         if (rd_pend_q) begin
            vid_rdata_q <= bus.ram_rdata;
         end
      end
   end

   assign bus.ram_addr  = ram_addr;
   assign bus.ram_wdata = ram_wdata;
   assign bus.ram_we    = ram_we;
   assign bus.host_ack  = host_ack;
   assign bus.host_err  = host_err;
   assign bus.clr_busy  = (state_q == StClear);
   assign bus.clr_done  = (state_q == StDone);
   assign bus.vid_valid = vid_valid_q;
   assign bus.vid_rdata = vid_rdata_q;
endmodule
